mux_sel_rr_arbiter: RTL and testbench
=====================================

Name: mux_sel_rr_arbiter

Overview:
- Round-robin arbiter that sits directly upstream of the 4:1 structural mux stage and drives its two select lines.
- Four requesters (channels A, B, C, D) compete for the single mux output.
- Grants are burst-based with a valid/ready handshake to the downstream consumer of the mux output O.
- Select encoding matches the mux exactly: {S1,S2} = 00 selects A, 01 selects B, 10 selects C, 11 selects D.

Parameters:
- BURST_LEN, 4, max accepted transfers per grant before forced rotation (1..7)
- CNT_W, 3, beat counter width; must satisfy 2^CNT_W > BURST_LEN

Ports:
- CLK  input  1  single clock, all state updates on rising edge
- RST_N  input  1  synchronous, active-low reset, sampled on rising edge of CLK
- REQ  input  4  per-channel request; bit0=A, bit1=B, bit2=C, bit3=D
- READY  input  1  downstream accepts mux output this cycle
- S1  output  1  mux select MSB (registered)
- S2  output  1  mux select LSB (registered)
- GNT  output  4  one-hot grant (registered); 0 when idle
- VALID  output  1  mux output O is valid this cycle
- LAST  output  1  current beat is final beat of the grant

Behaviour:
- States: IDLE, BUSY. Registers: sel[1:0] ({S1,S2}), GNT, ptr[1:0] (last granted channel), beat[CNT_W-1:0].
- Reset (RST_N=0 at a clock edge):
  - state=IDLE, S1=S2=0, GNT=0000, beat=0, ptr=3 (so channel A has top priority after reset).
  - Reset asserted mid-burst aborts the burst; there is no partial-grant memory.
- Arbitration function:
  - Search REQ starting at channel (ptr+1) mod 4 and wrapping.
  - The first set bit wins.
  - The previous owner is lowest priority.
- IDLE:
  - If REQ != 0, the next edge moves to BUSY: sel=winner, GNT=onehot(winner), ptr=winner, beat=0.
  - Otherwise remain in IDLE with outputs unchanged (S1/S2 hold their last value, GNT=0).
- BUSY outputs (combinational from registered state):
  - VALID = REQ[sel].
  - LAST = VALID & (beat == BURST_LEN-1).
- BUSY handshake:
  - A transfer occurs on an edge where VALID & READY.
  - On a transfer with LAST=0: beat increments.
- BUSY release conditions (evaluated each edge), either one:
  - a transfer occurs with LAST=1, or
  - REQ[sel]=0 (requester withdrew; no transfer counted).
- On release:
  - Re-arbitrate in the same edge over REQ with ptr = current sel.
  - If a winner exists: stay in BUSY, load new sel/GNT/ptr, beat=0. No bubble cycle.
  - If no winner: go to IDLE, GNT=0.
- Sole requester: a channel that is the only requester is re-granted immediately after its burst ends (new burst, beat=0).
- Back-pressure: READY=0 stalls; beat and grant hold indefinitely while VALID=1.
- Select timing: S1/S2 change only on grant edges, never mid-burst. VALID is combinational on REQ, so a requester must hold data stable while REQ=1.
- Throughput: at most one transfer per cycle. The first VALID appears one cycle after REQ rises from IDLE.
- BURST_LEN=1: every accepted beat forces rotation.

Test Plan:
- Reset then REQ=0001, READY=1 → next cycle GNT=0001, S1S2=00, VALID=1. After 4 beats LAST=1 on beat 4. Then re-grant A with no idle cycle.
- REQ=1111, READY=1 held → grants rotate A,B,C,D,A with S1S2=00,01,10,11,00. Each grant lasts exactly 4 VALID cycles, LAST on the 4th.
- REQ=0110 with READY toggling 1,0,1,0 → beat advances only on READY=1 cycles. B is granted for 8 cycles (4 transfers), then C.
- Granted B drops REQ after 2 beats while REQ[3]=1 → next edge GNT=1000, S1S2=11, beat=0. No transfer is counted for the withdrawal cycle.
- RST_N=0 mid-burst on C at beat 2 → next edge state=IDLE, GNT=0, S1S2=00, VALID=0. Afterwards REQ=1100 grants C first (ptr=3 after reset).
- REQ=0000 while BUSY at LAST transfer → IDLE, GNT=0, S1/S2 keep 11. A later REQ=0001 grants A.

Source files
------------

// File: rtl/mux_sel_rr_arbiter_if.sv
// Handshake bundle between the round-robin arbiter and the 4:1 mux stage / downstream consumer.
// The arbiter drives selects, grants and beat qualifiers; requesters and consumer drive REQ/READY.
interface mux_sel_rr_arbiter_if;
  logic [3:0] REQ;
  logic       READY;
  logic       S1;
  logic       S2;
  logic [3:0] GNT;
  logic       VALID;
  logic       LAST;

  modport master (
    input  REQ,
    input  READY,
    output S1,
    output S2,
    output GNT,
    output VALID,
    output LAST
  );

  modport slave (
    output REQ,
    output READY,
    input  S1,
    input  S2,
    input  GNT,
    input  VALID,
    input  LAST
  );
endinterface

// File: rtl/mux_sel_rr_arbiter.sv
// Burst-based round-robin arbiter driving the {S1,S2} selects of a 4:1 mux.
// Ownership rotates after BURST_LEN accepted beats or when the owner withdraws its request.
module mux_sel_rr_arbiter #(
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 3
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  mux_sel_rr_arbiter_if.master  bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } winner_t;

  localparam logic [CNT_W-1:0] BEAT_MAX = CNT_W'(BURST_LEN - 1);

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] beat_q, beat_d;

  logic       valid;
  logic       last;
  logic       xfer;
  logic [1:0] arb_ptr;
  winner_t    win;

  // Search starts one past the previous owner, so that owner is checked last.
  function automatic winner_t arbitrate(input logic [3:0] req, input logic [1:0] ptr);
    winner_t    w;
    logic [1:0] cand;
    w = '0;
    for (int i = 4; i >= 1; i--) begin
      cand = ptr + 2'(i);
      if (req[cand]) begin
        w.found = 1'b1;
        w.idx   = cand;
      end
    end
    return w;
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    beat_d  = beat_q;

    valid   = (state_q == BUSY) && bus.REQ[sel_q];
    last    = valid && (beat_q == BEAT_MAX);
    xfer    = valid && bus.READY;
    arb_ptr = (state_q == BUSY) ? sel_q : ptr_q;
    win     = arbitrate(bus.REQ, arb_ptr);

    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (win.found) begin
          state_d = BUSY;
          sel_d   = win.idx;
          gnt_d   = 4'b0001 << win.idx;
          ptr_d   = win.idx;
          beat_d  = '0;
        end
      end
      BUSY: begin
        // Release on the final accepted beat or on withdrawal; re-grant in the same edge.
        if ((xfer && last) || !bus.REQ[sel_q]) begin
          if (win.found) begin
            sel_d  = win.idx;
            gnt_d  = 4'b0001 << win.idx;
            ptr_d  = win.idx;
            beat_d = '0;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else if (xfer) begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      sel_q   <= 2'b00;
      gnt_q   <= 4'b0000;
      ptr_q   <= 2'd3;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
    end
  end

  assign bus.S1    = sel_q[1];
  assign bus.S2    = sel_q[0];
  assign bus.GNT   = gnt_q;
  assign bus.VALID = valid;
  assign bus.LAST  = last;

endmodule

// File: tb/tb_mux_sel_rr_arbiter.sv
// Self-checking bench for mux_sel_rr_arbiter: directed scenarios followed by random traffic,
// all compared against a channel-ownership reference model.
module tb_mux_sel_rr_arbiter;

  localparam int BURST_LEN = 4;
  localparam int CNT_W     = 3;

  logic clk;
  logic rst_n;

  mux_sel_rr_arbiter_if bus ();

  mux_sel_rr_arbiter #(
    .BURST_LEN (BURST_LEN),
    .CNT_W     (CNT_W)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int cycle      = 0;

  // Reference model: who owns the mux, how many beats it has delivered,
  // who was granted last, and which select value the mux is parked on.
  int m_owner;
  int m_beats;
  int m_ptr;
  int m_sel;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s @cycle %0d: observed=%0h expected=%0h", tag, cycle, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] req, input int from);
    for (int k = 1; k <= 4; k++) begin
      if (req[(from + k) % 4]) return (from + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_beats = 0;
    m_ptr   = 3;
    m_sel   = 0;
  endtask

  task automatic model_grant(input int w);
    m_owner = w;
    m_sel   = w;
    m_ptr   = w;
    m_beats = 0;
  endtask

  // One clock: apply inputs, check outputs against the model, then advance the model.
  task automatic step(input logic [3:0] req, input logic rdy, input logic rn);
    logic [3:0] exp_gnt;
    logic       exp_valid;
    logic       exp_last;
    int         w;
    @(negedge clk);
    bus.REQ   = req;
    bus.READY = rdy;
    rst_n     = rn;
    #1;
    exp_gnt   = 4'b0000;
    exp_valid = 1'b0;
    if (m_owner >= 0) begin
      exp_gnt   = 4'(1 << m_owner);
      exp_valid = req[m_owner];
    end
    exp_last = exp_valid && (m_beats == BURST_LEN - 1);
    check("GNT",   32'(bus.GNT),            32'(exp_gnt));
    check("S1S2",  32'({bus.S1, bus.S2}),   32'(m_sel));
    check("VALID", 32'(bus.VALID),          32'(exp_valid));
    check("LAST",  32'(bus.LAST),           32'(exp_last));

    if (!rn) begin
      model_reset();
    end else if (m_owner < 0) begin
      w = pick(req, m_ptr);
      if (w >= 0) model_grant(w);
    end else if ((exp_valid && rdy && exp_last) || !req[m_owner]) begin
      w = pick(req, m_owner);
      if (w >= 0) model_grant(w);
      else m_owner = -1;
    end else if (exp_valid && rdy) begin
      m_beats++;
    end
    @(posedge clk);
    cycle++;
  endtask

  initial begin
    logic [3:0] r;
    rst_n     = 1'b0;
    bus.REQ   = 4'b0000;
    bus.READY = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();

    // Reset state and idle hold
    repeat (2) step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b1);

    // Sole requester A: bursts of 4 with immediate re-grant
    repeat (11) step(4'b0001, 1'b1, 1'b1);

    // All requesting: A,B,C,D,A rotation
    step(4'b0000, 1'b1, 1'b0);
    repeat (22) step(4'b1111, 1'b1, 1'b1);

    // B and C with READY toggling
    step(4'b0000, 1'b1, 1'b0);
    for (int i = 0; i < 14; i++) step(4'b0110, (i % 2) == 1, 1'b1);

    // Granted B withdraws after 2 beats while D waits
    step(4'b0000, 1'b1, 1'b0);
    repeat (3) step(4'b1010, 1'b1, 1'b1);
    repeat (3) step(4'b1000, 1'b1, 1'b1);

    // Reset mid-burst on C, then C/D contend (C first)
    step(4'b0000, 1'b1, 1'b0);
    repeat (3) step(4'b0100, 1'b1, 1'b1);
    step(4'b0100, 1'b1, 1'b0);
    repeat (6) step(4'b1100, 1'b1, 1'b1);

    // D finishes and nobody requests: idle with selects parked at 11, then A
    step(4'b0000, 1'b1, 1'b0);
    repeat (5) step(4'b1000, 1'b1, 1'b1);
    repeat (3) step(4'b0000, 1'b1, 1'b1);
    repeat (3) step(4'b0001, 1'b1, 1'b1);

    // Long back-pressure stall mid-burst
    repeat (6) step(4'b0001, 1'b0, 1'b1);
    repeat (4) step(4'b0001, 1'b1, 1'b1);

    // Random traffic: requests change occasionally, READY mostly high, rare resets
    r = 4'($urandom_range(0, 15));
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) r = 4'($urandom_range(0, 15));
      step(r, $urandom_range(0, 3) != 0, $urandom_range(0, 60) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
